hazard5_muldiv_ctrl: RTL
========================

Name: hazard5_muldiv_ctrl

Overview:
Issue/retire controller between the Hazard5 execute stage and the sequential multiply/divide unit (hazard5_muldiv_seq).
- Accepts M-extension requests over a valid/ready handshake and issues them to the sequencer in a canonical form.
- Selects the high or low result half and returns it over a valid/ready handshake.
- Holds a one-entry result cache, so the paired op (MUL→MULH, DIV→REM, DIVU→REMU) on identical operands completes in one cycle without reissue.
- Handles pipeline flush of an in-flight operation.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  controller can accept a request
- req_op  in  3  M op, encoding from hazard5_ops.vh (M_OP_*)
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- res_vld  out  1  result valid
- res_rdy  in  1  consumer accepts result
- res_data  out  XLEN  selected result
- flush  in  1  kill current op, discard its result
- busy  out  1  state != IDLE
- m_op  out  3  sequencer op
- m_op_vld  out  1  sequencer op valid
- m_op_rdy  in  1  sequencer accepts op
- m_op_a  out  XLEN  sequencer operand a
- m_op_b  out  XLEN  sequencer operand b
- m_result_h  in  XLEN  sequencer high/remainder
- m_result_l  in  XLEN  sequencer low/quotient
- m_result_vld  in  1  sequencer completion

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous, active-low, rst_n. On reset, all of the following are 0: state=IDLE, m_op_vld, res_vld, res_data, m_op, m_op_a, m_op_b, cache_vld. The sequencer op_force is tied low at the top level.
- Canonical issue op:
  - MUL→MULH
  - MULH/MULHSU/MULHU→self
  - DIV, REM→DIV
  - DIVU, REMU→DIVU
- Half select: MUL, DIV and DIVU take m_result_l; all others take m_result_h.
- Cache contents: cache_vld, cache_op (canonical), cache_a, cache_b, cache_h, cache_l. Hit = cache_vld && canon(req_op)==cache_op && req_a==cache_a && req_b==cache_b.
- req_rdy = (state==IDLE) && !flush. Accept = req_vld && req_rdy. A request is never accepted in a flush cycle.
- IDLE:
  - Accept with hit → DONE; res_data loaded from the cache half next edge. res_vld is high on cycle N+1 for acceptance at edge N; no m_op_vld is generated.
  - Accept with miss → ISSUE; m_op/m_op_a/m_op_b are registered and m_op_vld=1 next cycle.
- ISSUE: hold m_op_vld and operands stable until m_op_rdy.
  - On m_op_rdy → WAIT, m_op_vld=0.
  - flush without m_op_rdy → IDLE (op dropped).
  - flush with m_op_rdy → DRAIN.
- WAIT: on m_result_vld, capture both halves into the cache (cache_vld=1) and load res_data with the selected half → DONE. flush → DRAIN. flush and m_result_vld in the same cycle → cache filled, go to IDLE, no result presented.
- DONE: res_vld=1 and res_data stable until res_rdy → IDLE. flush → IDLE with the result discarded; the cache is retained. Miss latency: res_vld is high on the cycle after the m_result_vld cycle.
- DRAIN: ignore flush. On m_result_vld, fill the cache → IDLE. res_vld is never asserted from DRAIN.
- Cache replacement: every completed sequencer op overwrites the cache. A miss clears cache_vld on acceptance (the entry is refilled on completion). Reset also clears cache_vld.
- Back-to-back: after the DONE→IDLE edge, the next request can be accepted in the following cycle; throughput is one hit per 2 cycles.
- Reset mid-operation: the controller returns to IDLE immediately. The sequencer shares rst_n, so there is no stale completion.

Decomposition:
- Shared package: M_OP_* encodings, already in hazard5_ops.vh.
- Add to hazard5_ops.vh: function/localparam canonical-op mapping and half-select predicate (op[2]^op[1]... as a named function), so decode and the bench share one definition.
- State encoding stays local.
- No sub-module; the cache is registers plus a comparator inline.

Test Plan:
- MUL 3,4 → one m_op_vld with m_op=MULH; res_data=0x0000000C.
- MUL 0xFFFFFFFF,2 then MULH same operands:
  - MUL → 0xFFFFFFFE.
  - MULH → 0xFFFFFFFF, res_vld one cycle after acceptance, zero m_op_vld pulses.
- DIV 0xFFFFFFF9,2 → 0xFFFFFFFD; then REM same operands → 0xFFFFFFFF as a hit. Then REMU same operands → miss, reissue as DIVU, result 0x00000001.
- Backpressure: res_rdy low 3 cycles in DONE → res_vld and res_data held; req_rdy=0 throughout.
- Flush during WAIT of DIVU 100,7:
  - No res_vld; DRAIN until m_result_vld, then IDLE.
  - Following REMU 100,7 hits → 0x00000002.
- Flush in ISSUE with m_op_rdy low → IDLE, no op reaches the sequencer. Assert rst_n=0 mid-WAIT → all outputs 0 asynchronously, cache invalid.

Source files
------------

// File: rtl/hazard5_muldiv_ctrl_pkg.sv
// rtl/hazard5_muldiv_ctrl_pkg.sv - M-extension op encodings and shared decode helpers
package hazard5_muldiv_ctrl_pkg;

    // M-extension op encodings (funct3 order).
    localparam logic [2:0] M_OP_MUL    = 3'd0;
    localparam logic [2:0] M_OP_MULH   = 3'd1;
    localparam logic [2:0] M_OP_MULHSU = 3'd2;
    localparam logic [2:0] M_OP_MULHU  = 3'd3;
    localparam logic [2:0] M_OP_DIV    = 3'd4;
    localparam logic [2:0] M_OP_DIVU   = 3'd5;
    localparam logic [2:0] M_OP_REM    = 3'd6;
    localparam logic [2:0] M_OP_REMU   = 3'd7;

    // Op actually sent to the sequencer. Paired ops collapse to one form so
    // that either member of a pair can hit on the other's cached result.
    function automatic logic [2:0] canon_op(input logic [2:0] op);
        logic [2:0] c;
        c = op;
        case (op)
            M_OP_MUL:           c = M_OP_MULH;
            M_OP_DIV, M_OP_REM: c = M_OP_DIV;
            M_OP_DIVU,
            M_OP_REMU:          c = M_OP_DIVU;
            default:            c = op;
        endcase
        return c;
    endfunction

    // True when the op returns the low/quotient half of the sequencer result.
    function automatic logic sel_lo(input logic [2:0] op);
        return (op == M_OP_MUL) || (op == M_OP_DIV) || (op == M_OP_DIVU);
    endfunction

endpackage

// File: rtl/hazard5_muldiv_ctrl.sv
// rtl/hazard5_muldiv_ctrl.sv - issue/retire controller for the sequential mul/div unit
//
// Accepts M-extension requests, issues them in canonical form to the
// sequencer, returns the selected result half, and keeps a one-entry cache
// of the last completed sequencer op so a paired op completes without reissue.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_vld/req_rdy/req_op/a/b       request handshake from execute stage
//   res_vld/res_rdy/res_data         result handshake back to execute stage
//   flush                            kill the current op, discard its result
//   busy                             controller not idle
//   m_op/m_op_vld/m_op_rdy/m_op_a/b  op handshake to the sequencer
//   m_result_h/l, m_result_vld       sequencer completion
module hazard5_muldiv_ctrl
    import hazard5_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            res_vld,
    input  logic            res_rdy,
    output logic [XLEN-1:0] res_data,
    input  logic            flush,
    output logic            busy,
    output logic [2:0]      m_op,
    output logic            m_op_vld,
    input  logic            m_op_rdy,
    output logic [XLEN-1:0] m_op_a,
    output logic [XLEN-1:0] m_op_b,
    input  logic [XLEN-1:0] m_result_h,
    input  logic [XLEN-1:0] m_result_l,
    input  logic            m_result_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic            cache_vld;
    logic [2:0]      cache_op;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic [XLEN-1:0] cache_h;
    logic [XLEN-1:0] cache_l;
    logic            pend_lo;   // half select of the op currently in flight

    logic accept;
    logic hit;
    logic complete;

    assign req_rdy  = (state == S_IDLE) && !flush;
    assign accept   = req_vld && req_rdy;
    assign hit      = cache_vld && (canon_op(req_op) == cache_op)
                      && (req_a == cache_a) && (req_b == cache_b);
    assign complete = m_result_vld && ((state == S_WAIT) || (state == S_DRAIN));

    assign m_op_vld = (state == S_ISSUE);
    assign res_vld  = (state == S_DONE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = hit ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Once the sequencer has taken the op it will complete, so a
                // flush on the handshake edge must still drain the result.
                if (m_op_rdy) begin
                    state_nxt = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (m_result_vld) begin
                    state_nxt = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush || res_rdy) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (m_result_vld) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            m_op      <= '0;
            m_op_a    <= '0;
            m_op_b    <= '0;
            pend_lo   <= 1'b0;
            cache_vld <= 1'b0;
            cache_op  <= '0;
            cache_a   <= '0;
            cache_b   <= '0;
            cache_h   <= '0;
            cache_l   <= '0;
        end else begin
            if (accept) begin
                pend_lo <= sel_lo(req_op);
                if (hit) begin
                    res_data <= sel_lo(req_op) ? cache_l : cache_h;
                end else begin
                    m_op      <= canon_op(req_op);
                    m_op_a    <= req_a;
                    m_op_b    <= req_b;
                    cache_vld <= 1'b0;
                end
            end
            // Issue registers stay stable through WAIT/DRAIN, so they name
            // the op that is completing.
            if (complete) begin
                cache_vld <= 1'b1;
                cache_op  <= m_op;
                cache_a   <= m_op_a;
                cache_b   <= m_op_b;
                cache_h   <= m_result_h;
                cache_l   <= m_result_l;
                if ((state == S_WAIT) && !flush) begin
                    res_data <= pend_lo ? m_result_l : m_result_h;
                end
            end
        end
    end

endmodule
